// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
package mem_arb_pkg;

    localparam int NREQ_DEF = 2;
    localparam int AW_DEF   = 3;
    localparam int DW_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: first set req bit searching upward from ptr, wrapping.
// A fixed ptr of 0 gives plain lowest-index-wins priority.
module mem_arb_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester arbiter for one single-port memory: IDLE -> ISSUE -> (RDWAIT) -> RESP.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               mem_wr,
    output logic               mem_rd,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state;
    logic [NREQ-1:0] win_oh;
    logic            win_wr;
    logic [IW-1:0]   ptr;
    logic [NREQ-1:0] pk_oh;
    logic [IW-1:0]   pk_idx;
    logic            pk_any;

    mem_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pk_oh),
        .idx (pk_idx),
        .any (pk_any)
    );

`ifdef MEM_ARB_RR_EN
    // ptr names the requester with top priority next time: one past the last winner
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (state == IDLE && pk_any)
            ptr <= (pk_idx == IW'(NREQ-1)) ? '0 : pk_idx + 1'b1;
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            win_oh    <= '0;
            win_wr    <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            case (state)
                IDLE: if (pk_any) begin
                    // outputs are registered, so the ISSUE-cycle strobes are loaded here
                    gnt      <= pk_oh;
                    win_oh   <= pk_oh;
                    win_wr   <= req_wr[pk_idx];
                    mem_wr   <= req_wr[pk_idx];
                    mem_rd   <= !req_wr[pk_idx];
                    mem_addr <= req_addr[pk_idx*AW +: AW];
                    mem_din  <= req_wdata[pk_idx*DW +: DW];
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (win_wr) begin
                        rsp_valid <= win_oh;
                        state     <= RESP;
                    end else begin
                        state     <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    rsp_rdata <= mem_dout;
                    rsp_valid <= win_oh;
                    state     <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
